// File: rtl/unif_event_monitor.sv
// Receiver for the two-channel uniform-delay event stream: synchronizes the lines,
// measures the start-to-event delay, checks it against per-channel windows and keeps statistics.
module unif_event_monitor #(
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int B0_MIN  = 3,
    parameter int B0_MAX  = 5,
    parameter int B1_MIN  = 0,
    parameter int B1_MAX  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit0,
    input  logic          bit1,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_chan,
    output logic [DW-1:0] res_delay,
    output logic          res_ok,
    output logic          res_timeout,
    output logic          res_both,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] err_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WAIT, REPORT} state_t;

    state_t        state;
    logic [DW-1:0] delay_cnt;
    logic [2:0]    sync1, sync2, prev;
    logic          start_edge, e0, e1;
    logic          in_win0, in_win1;
    logic          handshake;
    logic          err_inc;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Bit order {bit1, bit0, start}; all three lines see identical latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {bit1, bit0, start};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign start_edge = sync2[0] & ~prev[0];
    assign e0         = sync2[1] & ~prev[1];
    assign e1         = sync2[2] & ~prev[2];

    assign in_win0   = (int'(delay_cnt) >= B0_MIN) && (int'(delay_cnt) <= B0_MAX);
    assign in_win1   = (int'(delay_cnt) >= B1_MIN) && (int'(delay_cnt) <= B1_MAX);
    assign handshake = (state == REPORT) && res_ready;

    // One error increment per cycle, however many causes coincide.
    always_comb begin
        err_inc = 1'b0;
        case (state)
            IDLE:    err_inc = e0 | e1;
            WAIT:    err_inc = start_edge;
            REPORT:  err_inc = start_edge | e0 | e1 | (res_ready & ~res_ok);
            default: err_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            delay_cnt   <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            res_chan    <= 1'b0;
            res_delay   <= '0;
            res_ok      <= 1'b0;
            res_timeout <= 1'b0;
            res_both    <= 1'b0;
            cnt0        <= '0;
            cnt1        <= '0;
            err_cnt     <= '0;
        end else begin
            if (err_inc) err_cnt <= sat_inc(err_cnt);
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= WAIT;
                        busy      <= 1'b1;
                        delay_cnt <= '0;
                    end
                end
                WAIT: begin
                    // An event in the TIMEOUT cycle takes priority over the timeout.
                    if (e0 || e1) begin
                        state       <= REPORT;
                        res_valid   <= 1'b1;
                        res_delay   <= delay_cnt;
                        res_chan    <= e1;
                        res_both    <= e0 & e1;
                        res_timeout <= 1'b0;
                        res_ok      <= e1 ? (~e0 & in_win1) : in_win0;
                    end else if (delay_cnt == DW'(TIMEOUT)) begin
                        state       <= REPORT;
                        res_valid   <= 1'b1;
                        res_delay   <= DW'(TIMEOUT);
                        res_chan    <= 1'b0;
                        res_both    <= 1'b0;
                        res_timeout <= 1'b1;
                        res_ok      <= 1'b0;
                    end else begin
                        delay_cnt <= delay_cnt + DW'(1);
                    end
                end
                REPORT: begin
                    if (handshake) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        if (!res_timeout && !res_chan) cnt0 <= sat_inc(cnt0);
                        if (!res_timeout && res_chan)  cnt1 <= sat_inc(cnt1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unif_event_monitor.sv
// Directed self-checking bench for unif_event_monitor: window checks, timeout,
// simultaneous events, overrun, backpressure and asynchronous reset.
module tb_unif_event_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bit0 = 1'b0;
    logic        bit1 = 1'b0;
    logic        res_ready = 1'b0;
    logic        res_valid;
    logic        res_chan;
    logic [7:0]  res_delay;
    logic        res_ok;
    logic        res_timeout;
    logic        res_both;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [15:0] err_cnt;
    logic        busy;

    int checks = 0;
    int failures = 0;

    unif_event_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit0(bit0), .bit1(bit1),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
        .res_delay(res_delay), .res_ok(res_ok), .res_timeout(res_timeout),
        .res_both(res_both), .cnt0(cnt0), .cnt1(cnt1), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Event pins rise n+1 cycles after start so the measured delay is n.
    task automatic apply_stimulus(input int n, input logic ev0, input logic ev1);
        start = 1'b1;
        tick(n + 1);
        bit0 = ev0;
        bit1 = ev1;
        tick(1);
        start = 1'b0;
        bit0  = 1'b0;
        bit1  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (res_valid === 1'b1) break;
            tick(1);
        end
        check_output({tag, "_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic chan, input int delay,
                                input logic ok, input logic tmo, input logic both);
        check_output({tag, "_chan"}, 32'(res_chan), 32'(chan));
        check_output({tag, "_delay"}, 32'(res_delay), 32'(delay));
        check_output({tag, "_ok"}, 32'(res_ok), 32'(ok));
        check_output({tag, "_timeout"}, 32'(res_timeout), 32'(tmo));
        check_output({tag, "_both"}, 32'(res_both), 32'(both));
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        tick(3);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_output("rst_valid", 32'(res_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_err", 32'(err_cnt), 32'd0);
        check_output("rst_cnt0", 32'(cnt0), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // bit0 inside window
        apply_stimulus(4, 1'b1, 1'b0);
        wait_result("b0d4", 20);
        check_result("b0d4", 1'b0, 4, 1'b1, 1'b0, 1'b0);
        check_output("b0d4_busy", 32'(busy), 32'd1);
        accept_result();
        check_output("b0d4_cnt0", 32'(cnt0), 32'd1);
        check_output("b0d4_err", 32'(err_cnt), 32'd0);
        check_output("b0d4_idle", 32'(busy), 32'd0);

        // bit0 window boundaries
        apply_stimulus(2, 1'b1, 1'b0);
        wait_result("b0d2", 20);
        check_result("b0d2", 1'b0, 2, 1'b0, 1'b0, 1'b0);
        accept_result();
        apply_stimulus(3, 1'b1, 1'b0);
        wait_result("b0d3", 20);
        check_result("b0d3", 1'b0, 3, 1'b1, 1'b0, 1'b0);
        accept_result();
        apply_stimulus(5, 1'b1, 1'b0);
        wait_result("b0d5", 20);
        check_result("b0d5", 1'b0, 5, 1'b1, 1'b0, 1'b0);
        accept_result();
        apply_stimulus(6, 1'b1, 1'b0);
        wait_result("b0d6", 20);
        check_result("b0d6", 1'b0, 6, 1'b0, 1'b0, 1'b0);
        accept_result();
        check_output("bnd_err", 32'(err_cnt), 32'd2);
        check_output("bnd_cnt0", 32'(cnt0), 32'd5);

        // bit1 at delay 0
        apply_stimulus(0, 1'b0, 1'b1);
        wait_result("b1d0", 20);
        check_result("b1d0", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        accept_result();
        check_output("b1d0_cnt1", 32'(cnt1), 32'd1);

        // Timeout
        start = 1'b1;
        tick(2);
        start = 1'b0;
        wait_result("tmo", 40);
        check_result("tmo", 1'b0, 16, 1'b0, 1'b1, 1'b0);
        accept_result();
        check_output("tmo_cnt0", 32'(cnt0), 32'd5);
        check_output("tmo_cnt1", 32'(cnt1), 32'd1);
        check_output("tmo_err", 32'(err_cnt), 32'd3);

        // Both channels at delay 2, with a second start edge during WAIT
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        bit0 = 1'b1;
        bit1 = 1'b1;
        tick(1);
        start = 1'b0;
        bit0  = 1'b0;
        bit1  = 1'b0;
        wait_result("both", 20);
        check_result("both", 1'b1, 2, 1'b0, 1'b0, 1'b1);
        check_output("ovr_err", 32'(err_cnt), 32'd4);
        accept_result();
        check_output("both_err", 32'(err_cnt), 32'd5);
        check_output("both_cnt1", 32'(cnt1), 32'd2);

        // Backpressure with stray edges, then reset mid-REPORT
        apply_stimulus(4, 1'b1, 1'b0);
        wait_result("bp", 20);
        tick(1);
        bit1 = 1'b1;
        tick(1);
        bit1 = 1'b0;
        tick(2);
        bit0  = 1'b1;
        start = 1'b1;
        tick(1);
        bit0  = 1'b0;
        start = 1'b0;
        tick(5);
        check_result("bp", 1'b0, 4, 1'b1, 1'b0, 1'b0);
        check_output("bp_valid_held", 32'(res_valid), 32'd1);
        check_output("bp_err", 32'(err_cnt), 32'd7);
        rst_n = 1'b0;
        #1;
        check_output("arst_valid", 32'(res_valid), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_delay", 32'(res_delay), 32'd0);
        check_output("arst_cnt0", 32'(cnt0), 32'd0);
        check_output("arst_cnt1", 32'(cnt1), 32'd0);
        check_output("arst_err", 32'(err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unif_event_monitor.md
Name: unif_event_monitor

Overview:
- Synthesizable receiver for the two-channel random event stream from the uniform-delay stimulus generator.
- Protocol: a `start` strobe marks a decision; exactly one of `bit0`/`bit1` then rises after a channel-specific delay.
- Block synchronizes the lines, measures the start-to-event delay in clock cycles, and checks it against per-channel windows.
- Each decision yields one result via valid/ready; running counts are kept for regression scoreboards.

Parameters:
- DW, 8, delay counter width.
- CW, 16, statistics counter width.
- B0_MIN, 3, minimum legal bit0 delay (cycles).
- B0_MAX, 5, maximum legal bit0 delay (cycles).
- B1_MIN, 0, minimum legal bit1 delay (cycles).
- B1_MAX, 3, maximum legal bit1 delay (cycles).
- TIMEOUT, 16, cycles without an event before abort; must be < 2^DW.

Ports:
- clk  in  1  single clock; everything samples on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  async decision strobe; rising edge is the event.
- bit0  in  1  async channel-0 event; rising edge is the event.
- bit1  in  1  async channel-1 event; rising edge is the event.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_chan  out  1  0 = bit0, 1 = bit1 (0 on timeout).
- res_delay  out  DW  measured delay in cycles.
- res_ok  out  1  delay inside the channel window, single event, no timeout.
- res_timeout  out  1  no event within TIMEOUT.
- res_both  out  1  both channels rose in the same cycle.
- cnt0  out  CW  accepted bit0 results; saturating.
- cnt1  out  CW  accepted bit1 results; saturating.
- err_cnt  out  CW  protocol errors; saturating.
- busy  out  1  state != IDLE.

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-low.
- Reset: state = IDLE; all outputs 0; synchronizer and edge-history flops cleared to 0.
- Input path: `start`, `bit0`, `bit1` each pass a 2-flop synchronizer, then a rising-edge detector (sync & ~prev).
  - Pin-to-detect latency is 3 cycles, equal on all lines, so it cancels in the delay measurement.
- IDLE:
  - Start edge -> WAIT; delay counter := 0.
  - bit0/bit1 edge -> spurious; err_cnt += 1 per cycle containing any spurious edge.
- WAIT:
  - Counter increments every cycle; the first cycle after entry holds 0.
  - Event edge in a cycle with counter value N -> res_delay := N.
  - res_chan := channel; res_both := both edges this cycle (res_chan := 1 in that case).
  - res_ok := !both && MIN <= N <= MAX for that channel.
  - Then -> REPORT.
  - Counter reaching TIMEOUT with no event -> res_timeout := 1, res_delay := TIMEOUT, res_ok := 0 -> REPORT.
  - An event coinciding with the TIMEOUT cycle wins over timeout.
  - Start edge in WAIT: overrun; err_cnt += 1; measurement continues unchanged.
- REPORT:
  - res_valid = 1; all res_* fields stable until the handshake.
  - res_valid && res_ready -> IDLE next cycle; res_valid drops.
  - At handshake: cnt0 += 1 if chan = 0 and !timeout; cnt1 += 1 if chan = 1 and !timeout.
  - At handshake: err_cnt += 1 if !res_ok.
  - Any start or event edge while in REPORT counts as an error (+1 per cycle) and is otherwise dropped.
- err_cnt increments at most 1 per cycle; coincident causes are not double-counted.
- Counters stick at 2^CW-1.
- Reset mid-operation aborts immediately: no result emitted, counters cleared.
- res_* fields hold their last values in IDLE; only res_valid qualifies them.

Test Plan:
- Window pass, bit0: start edge, bit0 edge 4 cycles later, res_ready = 1 -> res_valid with chan = 0, delay = 4, ok = 1; cnt0 = 1, err_cnt = 0.
- bit0 boundaries: delays 2, 3, 5, 6 -> ok = 0, 1, 1, 0; err_cnt = 2 after all four are accepted.
- bit1 at delay 0 (event detected the cycle after start) -> chan = 1, delay = 0, ok = 1, cnt1 = 1.
- Timeout: start only -> after 16 cycles res_timeout = 1, delay = 16, ok = 0; cnt0 and cnt1 unchanged, err_cnt = 1.
- Simultaneous events: bit0 and bit1 rise together at delay 2 -> res_both = 1, chan = 1, ok = 0.
  - Second start during WAIT -> err_cnt +1 and the original delay is still reported correctly.
- Backpressure and reset: hold res_ready = 0 for 10 cycles -> fields stable, extra edges add err_cnt.
  - Then assert rst_n = 0 mid-REPORT -> all outputs 0 immediately, busy = 0.
